// File: rtl/seq_alu_pkg.sv
// Shared opcode values, FSM encoding and opcode predicates for seq_alu.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_SBB = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_valid(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SBB);
  endfunction

  function automatic logic op_rotate(input logic [3:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/seq_alu_core.sv
// Single-cycle combinational datapath; rotates pass `a` through (the top steps them).
// Latency 0; no flow control of its own.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 cf,
  input  logic [3:0]           opcode,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 carry,
  output logic                 borrow,
  output logic                 invalid
);

  logic [BUS_WIDTH:0] ax, bx, cx, one, sum;

  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = {{BUS_WIDTH{1'b0}}, cf};
  assign one = {{BUS_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    sum     = '0;
    result  = '0;
    carry   = 1'b0;
    borrow  = 1'b0;
    invalid = !op_valid(opcode);
    // The extra MSB of `sum` is the carry or the borrow depending on the op.
    case (opcode)
      OP_ADD: begin sum = ax + bx;      carry  = sum[BUS_WIDTH]; result = sum[BUS_WIDTH-1:0]; end
      OP_ADC: begin sum = ax + bx + cx; carry  = sum[BUS_WIDTH]; result = sum[BUS_WIDTH-1:0]; end
      OP_INC: begin sum = ax + one;     carry  = sum[BUS_WIDTH]; result = sum[BUS_WIDTH-1:0]; end
      OP_SUB: begin sum = ax - bx;      borrow = sum[BUS_WIDTH]; result = sum[BUS_WIDTH-1:0]; end
      OP_SBB: begin sum = ax - bx - cx; borrow = sum[BUS_WIDTH]; result = sum[BUS_WIDTH-1:0]; end
      OP_DEC: begin sum = ax - one;     borrow = sum[BUS_WIDTH]; result = sum[BUS_WIDTH-1:0]; end
      OP_AND: result = a & b;
      OP_NOT: result = ~a;
      OP_ROL, OP_ROR: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with carry chaining and bit-serial rotate, valid/ready on both sides.
// Latency 1 edge (rotate by n: n+1); in_ready follows out_ready while a result is held.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int BUS_WIDTH = 8,
  localparam int SH_W      = $clog2(BUS_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [3:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);

  state_t               state, state_nxt;
  logic [SH_W-1:0]      cnt;
  logic [BUS_WIDTH-1:0] work, work_rot, core_res, y_nxt;
  logic                 dir_left, cf;
  logic                 core_carry, core_borrow, core_inv;
  logic                 accept, start_busy, load_core, load_rot;

  seq_alu_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
    .a       (a),
    .b       (b),
    .cf      (cf),
    .opcode  (opcode),
    .result  (core_res),
    .carry   (core_carry),
    .borrow  (core_borrow),
    .invalid (core_inv)
  );

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept     = in_valid && in_ready;
  assign start_busy = op_rotate(opcode) && (b[SH_W-1:0] != '0);
  assign load_core  = accept && !start_busy;
  assign load_rot   = (state == ST_BUSY) && (cnt == SH_W'(1));
  assign out_valid  = (state == ST_DONE);
  assign work_rot   = dir_left ? {work[BUS_WIDTH-2:0], work[BUS_WIDTH-1]}
                               : {work[0], work[BUS_WIDTH-1:1]};
  assign y_nxt      = load_rot ? work_rot : core_res;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = start_busy ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt == SH_W'(1)) state_nxt = ST_DONE;
      ST_DONE: begin
        if (accept)         state_nxt = start_busy ? ST_BUSY : ST_DONE;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cf         <= 1'b0;
      cnt        <= '0;
      work       <= '0;
      dir_left   <= 1'b0;
      y          <= '0;
      carry_out  <= 1'b0;
      borrow     <= 1'b0;
      invalid_op <= 1'b0;
      zero       <= 1'b1;
      parity     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Core reports carry/borrow only for the six arithmetic ops; others keep cf.
      if (accept && (core_carry || core_borrow || opcode inside {OP_ADD, OP_ADC, OP_INC,
                                                                 OP_SUB, OP_SBB, OP_DEC}))
        cf <= core_carry | core_borrow;
      if (accept && start_busy) begin
        cnt      <= b[SH_W-1:0];
        work     <= a;
        dir_left <= (opcode == OP_ROL);
      end else if (state == ST_BUSY) begin
        cnt  <= cnt - SH_W'(1);
        work <= work_rot;
      end
      if (load_core || load_rot) begin
        y          <= y_nxt;
        carry_out  <= load_rot ? 1'b0 : core_carry;
        borrow     <= load_rot ? 1'b0 : core_borrow;
        invalid_op <= load_rot ? 1'b0 : core_inv;
        zero       <= ~|y_nxt;
        parity     <= ^y_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed literal checks plus randomized traffic against a
// transaction-level model compared on every cycle.
module tb_seq_alu;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, y;
  logic [3:0]   opcode;
  logic         carry_out, borrow, zero, parity, invalid_op;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  seq_alu #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .carry_out  (carry_out),
    .borrow     (borrow),
    .zero       (zero),
    .parity     (parity),
    .invalid_op (invalid_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    int y;
    bit c, bw, z, p, inv;
  } res_t;

  function automatic res_t mk(input int yy, input bit c, input bit bw, input bit inv);
    res_t r;
    r.y = yy; r.c = c; r.bw = bw; r.inv = inv;
    r.z = (yy == 0);
    r.p = $countones(yy) % 2;
    return r;
  endfunction

  // Reference semantics straight from the op table, in plain integer arithmetic.
  function automatic void model_op(input int op, input int x, input int z, input bit cfi,
                                   output res_t r, output bit ncf, output int lat);
    int n, s;
    n = z % W; ncf = cfi; lat = 1;
    case (op)
      1:  begin s = x + z;       r = mk(s & MASK, s > MASK, 0, 0); ncf = s > MASK; end
      2:  begin s = x + z + cfi; r = mk(s & MASK, s > MASK, 0, 0); ncf = s > MASK; end
      4:  begin s = x + 1;       r = mk(s & MASK, s > MASK, 0, 0); ncf = s > MASK; end
      3:  begin r = mk((x - z) & MASK, 0, x < z, 0);          ncf = x < z; end
      10: begin r = mk((x - z - cfi) & MASK, 0, x < z + cfi, 0); ncf = x < z + cfi; end
      5:  begin r = mk((x - 1) & MASK, 0, x == 0, 0);         ncf = (x == 0); end
      6:  r = mk(x & z, 0, 0, 0);
      7:  r = mk(~x & MASK, 0, 0, 0);
      8:  begin r = mk(((x << n) | (x >> (W - n))) & MASK, 0, 0, 0); lat = n + 1; end
      9:  begin r = mk(((x >> n) | (x << (W - n))) & MASK, 0, 0, 0); lat = n + 1; end
      default: r = mk(0, 0, 0, 1);
    endcase
  endfunction

  res_t last_r, pend_r;
  bit   pending = 0, m_cf = 0, armed = 0;
  int   ready_cyc = 0;

  always @(negedge clk) begin
    bit   exp_ov, exp_ir, ncf;
    res_t e, r;
    int   lat;
    exp_ov = pending && (cyc >= ready_cyc);
    exp_ir = !reset && (!pending || (exp_ov && out_ready));
    e      = exp_ov ? pend_r : last_r;
    if (armed)
      chk("outputs{ov,ir,y,c,bw,z,p,inv}",
          {out_valid, in_ready, y, carry_out, borrow, zero, parity, invalid_op},
          {exp_ov, exp_ir, e.y[W-1:0], e.c, e.bw, e.z, e.p, e.inv});
    if (reset) begin
      armed = 1; pending = 0; m_cf = 0; last_r = mk(0, 0, 0, 0);
    end else if (armed) begin
      if (exp_ov && out_ready) begin last_r = pend_r; pending = 0; end
      if (in_valid && exp_ir) begin
        model_op(opcode, a, b, m_cf, r, ncf, lat);
        pend_r = r; m_cf = ncf; pending = 1; ready_cyc = cyc + lat;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int k = 0;
    opcode = op; a = aa; b = bb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_y", y, 0);
    chk("reset_zero", zero, 1);
    chk("reset_flags", {carry_out, borrow, parity, invalid_op}, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);

    send(4'd1, 8'hF0, 8'h20);
    chk("add_y", y, 8'h10);  chk("add_carry", carry_out, 1);
    send(4'd2, 8'h01, 8'h00);
    chk("adc_y", y, 8'h02);  chk("adc_carry", carry_out, 0);
    send(4'd3, 8'h05, 8'h07);
    chk("sub_y", y, 8'hFE);  chk("sub_borrow", borrow, 1); chk("sub_parity", parity, 1);
    send(4'd10, 8'h00, 8'h00);
    chk("sbb_y", y, 8'hFF);  chk("sbb_borrow", borrow, 1);

    send(4'd8, 8'h81, 8'h03);
    chk("rol_busy_ir", {out_valid, in_ready}, 2'b00);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rol_busy_ir", {out_valid, in_ready}, 2'b00);
    end
    @(posedge clk); #1;
    chk("rol_valid", out_valid, 1); chk("rol_y", y, 8'h0C);
    send(4'd9, 8'h81, 8'h08);
    chk("ror0_valid", out_valid, 1); chk("ror0_y", y, 8'h81);

    send(4'd6, 8'hAA, 8'h0F);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_state", {out_valid, in_ready, y}, {2'b10, 8'h0A});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", out_valid, 0);

    send(4'd1, 8'hFF, 8'h01);
    chk("carry_setup", {carry_out, y}, {1'b1, 8'h00});
    send(4'd0, 8'h12, 8'h34);
    chk("inv0", {invalid_op, zero, y}, {2'b11, 8'h00});
    send(4'd15, 8'h56, 8'h78);
    chk("inv15", {invalid_op, zero, parity, y}, {3'b110, 8'h00});
    send(4'd2, 8'h00, 8'h00);
    chk("adc_cf_kept", y, 8'h01);

    send(4'd8, 8'h81, 8'h05);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", out_valid, 0); chk("rst_mid_y", y, 0);
    chk("rst_mid_ir_held", in_ready, 0);
    reset = 1'b0;
    #1 chk("rst_mid_ir", in_ready, 1);
    send(4'd2, 8'h00, 8'h00);
    chk("cf_cleared", {carry_out, y}, {1'b0, 8'h00});
    repeat (8) @(posedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 4'($urandom_range(0, 15));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, handshaked successor to the combinational ALU, parametrised in `BUS_WIDTH`. It adds:
- a persistent carry/borrow flag for multi-word add/subtract chains,
- multi-cycle rotate by a variable amount,
- valid/ready flow control on both sides.

It sits between an operand-issue stage and a result consumer. Every output is registered.

## Interface
- `BUS_WIDTH`, 8: operand/result width; must be ≥ 2. `SH_W = $clog2(BUS_WIDTH)`.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand/opcode presented.
- `in_ready` output 1: block can accept; transfer when `in_valid && in_ready` at a rising edge.
- `a`, `b` input BUS_WIDTH: operands; `b[SH_W-1:0]` is the rotate amount for ROL/ROR.
- `opcode` input 4: operation select.
- `out_valid` output 1: result registers hold an unconsumed result.
- `out_ready` input 1: consumer accepts; result leaves when `out_valid && out_ready`.
- `y` output BUS_WIDTH: result.
- `carry_out`, `borrow`, `zero`, `parity`, `invalid_op` output 1 each: status for `y`.

## Operation
- Opcodes:
  - 1 ADD: `{c,y}=a+b`.
  - 2 ADC: `a+b+cf`.
  - 3 SUB: `{bw,y}=a-b`.
  - 4 INC: `a+1`.
  - 5 DEC: `a-1`.
  - 6 AND: `a&b`.
  - 7 NOT: `~a`.
  - 8 ROL: rotate `a` left by `b[SH_W-1:0]`.
  - 9 ROR: rotate `a` right by the same amount.
  - 10 SBB: `a-b-cf`.
  - 0 and 11–15 are invalid.
- Arithmetic is computed at BUS_WIDTH+1 bits. The MSB is the carry (ADD/ADC/INC) or the borrow (SUB/SBB/DEC).
- Internal flag `cf`:
  - ADD/ADC/INC load `cf` with carry; SUB/SBB/DEC load `cf` with borrow.
  - All other ops, including invalid ones, leave `cf` unchanged.
  - Reset clears `cf` to 0.
- Output flags:
  - `carry_out` is set only by ADD/ADC/INC; `borrow` is set only by SUB/SBB/DEC. Otherwise both are 0.
  - `zero = (y==0)` and `parity = ^y` are registered with `y`.
- Invalid opcode: `y=0`, `invalid_op=1`, `zero=1`, `parity=0`, `cf` unchanged.
- FSM states:
  - IDLE: `in_ready=1`.
    - Accept of a non-rotate op, or a rotate with amount 0, goes to DONE.
    - Accept of a rotate with amount n>0 goes to BUSY with `cnt=n`, `work=a`.
  - BUSY: `in_ready=0`.
    - Each edge rotates `work` by 1 in the selected direction and decrements `cnt`.
    - The edge where `cnt` goes 1→0 loads `y` and goes to DONE.
  - DONE: `out_valid=1`.
    - `out_ready=1` with no new accept goes to IDLE.
    - `in_ready = out_ready`, so a back-to-back accept is allowed and follows the IDLE accept rules.
- Results are held stable while `out_valid && !out_ready`.

## Timing
- Reset (synchronous):
  - State = IDLE, `cf=0`, `cnt=0`.
  - `y=0`, `carry_out=0`, `borrow=0`, `invalid_op=0`, `out_valid=0`.
  - `zero=1`, `parity=0`.
  - `in_ready=0` while `reset` is high.
- Reset mid-operation (BUSY or DONE) aborts the operation. The pending result is discarded and no `out_valid` is produced for it.
- Latency from accept edge to `out_valid` high:
  - Non-rotate ops: 1 edge.
  - Rotate by n: n+1 edges, with n ≤ BUSY_WIDTH-1.
- Throughput: one non-rotate op per cycle when `out_ready` is held high.
- Chaining: ADC/SBB use the `cf` value updated by the immediately preceding accepted op, with no bubble.
- `in_ready` is combinational from state and `out_ready` only; it never depends on `in_valid`.

## Structure
- Package `seq_alu_pkg` holds:
  - opcode localparams `OP_ADD`..`OP_SBB`,
  - FSM state encoding (`ST_IDLE`, `ST_BUSY`, `ST_DONE`),
  - a function returning the valid-opcode predicate.
- Sub-module `seq_alu_core`: purely combinational single-cycle datapath.
  - Inputs: `a`, `b`, `cf`, `opcode`.
  - Outputs: result, carry, borrow, invalid.
  - The top level holds the FSM, rotate counter, `cf` and the output registers.

## Test plan
- ADD `a=0xF0,b=0x20`, then ADC `a=0x01,b=0x00` back-to-back → `y=0x10, carry_out=1`, then `y=0x02, carry_out=0`, one cycle apart.
- SUB `a=0x05,b=0x07`, then SBB `a=0x00,b=0x00`:
  - first result: `y=0xFE, borrow=1, parity=1`;
  - second result: `y=0xFF, borrow=1`.
- ROL `a=0x81,b=0x03` → `out_valid` 4 edges after accept, `y=0x0C`, `in_ready=0` during BUSY. ROR `a=0x81,b=0x08` (amount 0) → `y=0x81` after 1 edge.
- Hold `out_ready=0` for 5 cycles after AND `0xAA&0x0F` → `y=0x0A` stable, `out_valid=1`, `in_ready=0` throughout; release → single transfer.
- Opcode 0, then opcode 15 → `invalid_op=1, y=0, zero=1`; a following ADC `0x00+0x00` after prior carry=1 → `y=0x01` (`cf` preserved).
- Assert `reset` in the 2nd BUSY cycle of ROL by 5 → next cycle `out_valid=0`, `y=0`, `cf=0`, `in_ready=1` after `reset` is deasserted; no stale result appears.
